// File: rtl/quant_seq_pkg.sv
// Shared types and constants for the requantization stream sequencer.
// Q8.24 scale constant and byte-packing factor live here with the FSM state type.
package quant_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int          PACK = 4;
  localparam logic [31:0] ONE  = 32'h0100_0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy count.
// Used to buffer quantizer results, which arrive whether or not the packer can take them.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is left unreset; the count guards every read, so a reset port on the array would only cost area.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && full));
  end

endmodule

// File: rtl/quant_stream_sequencer.sv
// Streams one job of int32 accumulators through the external quantizer and packs the
// int8 results four per word into the output buffer, honouring write backpressure.
module quant_stream_sequencer
  import quant_seq_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 16,
  parameter int QLAT       = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [31:0]       scale,
  output logic              busy,
  output logic              done,
  output logic              acc_rd_en,
  output logic [ADDR_W-1:0] acc_rd_addr,
  input  logic [31:0]       acc_rd_data,
  output logic [31:0]       q_value,
  output logic [31:0]       q_scale,
  output logic              q_valid,
  input  logic [7:0]        q_result,
  input  logic              q_result_valid,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [31:0]       out_wr_data,
  input  logic              out_wr_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < QLAT + 2) begin : g_depth_check
    $error("FIFO_DEPTH must cover the quantizer latency plus two");
  end

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_r, issue_cnt, pop_cnt;
  logic [ADDR_W-1:0] src_r;
  logic [31:0]       scale_r, word_nxt;
  logic [CNT_W-1:0]  inflight, fifo_count;
  logic [CNT_W:0]    credit_sum;
  logic [1:0]        byte_idx;
  logic [7:0]        fifo_dout;
  logic              fifo_empty, res_accept, pop, last_elem, last_word, wr_accept;

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign q_value     = acc_rd_data;
  assign q_scale     = scale_r;
  assign acc_rd_addr = src_r + ADDR_W'(issue_cnt);

  // Every issued read owns a FIFO slot until its byte is popped, so the FIFO can never overflow.
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
  assign acc_rd_en  = (state == S_RUN) && (credit_sum < DEPTH_C);

  // Results with no outstanding read are leftovers from an aborted job still in the quantizer.
  assign res_accept = q_result_valid && busy && (inflight != '0);
  assign wr_accept  = out_wr_en && out_wr_ready;
  assign pop        = !fifo_empty && (!out_wr_en || out_wr_ready);
  assign last_elem  = (pop_cnt == len_r - 1'b1);

  always_comb begin
    word_nxt = (byte_idx == '0) ? '0 : out_wr_data;
    word_nxt[8*byte_idx +: 8] = fifo_dout;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (res_accept),
    .din   (q_result),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // NOTE: defaulting state_nxt before the case keeps this block purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (length == '0) ? S_DONE : S_RUN;
      S_RUN:   if (acc_rd_en && (issue_cnt == len_r - 1'b1)) state_nxt = S_DRAIN;
      S_DRAIN: if (wr_accept && last_word) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: non-blocking assignments throughout, so the later pop branch can override the accept branch cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_r       <= '0;
      src_r       <= '0;
      scale_r     <= '0;
      issue_cnt   <= '0;
      pop_cnt     <= '0;
      inflight    <= '0;
      byte_idx    <= '0;
      last_word   <= 1'b0;
      q_valid     <= 1'b0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
    end else begin
      q_valid <= acc_rd_en;

      if (state == S_IDLE && start) begin
        len_r       <= length;
        src_r       <= src_base;
        scale_r     <= scale;
        out_wr_addr <= dst_base;
        issue_cnt   <= '0;
        pop_cnt     <= '0;
        byte_idx    <= '0;
        last_word   <= 1'b0;
      end

      if (acc_rd_en) issue_cnt <= issue_cnt + 1'b1;

      case ({acc_rd_en, res_accept})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (wr_accept) begin
        out_wr_en   <= 1'b0;
        out_wr_addr <= out_wr_addr + 1'b1;
      end

      if (pop) begin
        out_wr_data <= word_nxt;
        byte_idx    <= byte_idx + 1'b1;
        pop_cnt     <= pop_cnt + 1'b1;
        if (byte_idx == 2'(PACK - 1) || last_elem) begin
          out_wr_en <= 1'b1;
          last_word <= last_elem;
          byte_idx  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_quant_stream_sequencer.sv
// Randomized self-checking bench: behavioural quantizer and buffers around the DUT,
// expected output words computed directly from the accumulator contents.
module tb_quant_stream_sequencer;
  import quant_seq_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 16;
  localparam int QLAT   = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  length = '0;
  logic [ADDR_W-1:0] src_base = '0, dst_base = '0;
  logic [31:0]       scale = '0;
  logic              busy, done, acc_rd_en, q_valid, out_wr_en;
  logic [ADDR_W-1:0] acc_rd_addr, out_wr_addr;
  logic [31:0]       acc_rd_data = '0, q_value, q_scale, out_wr_data;
  logic [7:0]        q_result;
  logic              q_result_valid;
  logic              out_wr_ready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  quant_stream_sequencer #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .QLAT(QLAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .src_base(src_base), .dst_base(dst_base), .scale(scale),
    .busy(busy), .done(done),
    .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
    .q_value(q_value), .q_scale(q_scale), .q_valid(q_valid),
    .q_result(q_result), .q_result_valid(q_result_valid),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .out_wr_ready(out_wr_ready)
  );

  always #5 clk = ~clk;

  // Reference quantizer: round toward minus infinity, saturate to int8.
  function automatic logic [7:0] quant(input logic [31:0] v, input logic [31:0] s);
    longint p;
    p = (longint'($signed(v)) * longint'(s)) >>> 24;
    if (p > 127)  return 8'h7f;
    if (p < -128) return 8'h80;
    return p[7:0];
  endfunction

  // Accumulator buffer: one-cycle read latency.
  logic [31:0] acc_mem [1024];
  always @(posedge clk) if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];

  // Non-stallable quantizer pipeline, never reset, so stale results keep flowing.
  logic [8:0] qpipe [QLAT] = '{default: '0};
  always @(posedge clk) begin
    qpipe[0] <= {q_valid, quant(q_value, q_scale)};
    for (int i = 1; i < QLAT; i++) qpipe[i] <= qpipe[i-1];
  end
  assign q_result_valid = qpipe[QLAT-1][8];
  assign q_result       = qpipe[QLAT-1][7:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_job(input int len, input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                         input logic [31:0] scl, input int ready_pct,
                         input int stall_from, input int stall_len, input bit restart);
    logic [31:0] exp_q[$];
    logic [41:0] got_q[$];
    int nwords, done_cnt, first_done, rd_cnt, viol, tail, budget;
    bit prev_pend;
    logic [41:0] prev_wr;
    nwords = (len + 3) / 4;
    for (int j = 0; j < nwords; j++) begin
      logic [31:0] w;
      w = '0;
      for (int b = 0; b < PACK; b++)
        if (4*j + b < len) w[8*b +: 8] = quant(acc_mem[ADDR_W'(int'(src) + 4*j + b)], scl);
      exp_q.push_back(w);
    end
    done_cnt = 0; first_done = -1; rd_cnt = 0; viol = 0; tail = 0; prev_pend = 0;
    prev_wr = '0;
    budget = 400 + 6*len;
    @(negedge clk);
    length = LEN_W'(len); src_base = src; dst_base = dst; scale = scl; start = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b0;
        length = LEN_W'($urandom_range(1, 50)); src_base = ADDR_W'($urandom);
        dst_base = ADDR_W'($urandom); scale = $urandom;
      end
      if (restart) start = (cyc == 3);
      if (cyc >= stall_from && cyc < stall_from + stall_len) out_wr_ready = 1'b0;
      else out_wr_ready = ($urandom_range(99) < ready_pct);
      if (prev_pend && (!out_wr_en || {out_wr_addr, out_wr_data} != prev_wr)) viol++;
      prev_pend = out_wr_en && !out_wr_ready;
      prev_wr   = {out_wr_addr, out_wr_data};
      if (acc_rd_en) rd_cnt++;
      if (out_wr_en && out_wr_ready) got_q.push_back({out_wr_addr, out_wr_data});
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
      end
      if (done_cnt > 0) tail++;
      if (tail > 3) break;
    end
    out_wr_ready = 1'b1;
    check($sformatf("len%0d_done_count", len), done_cnt, 1);
    check($sformatf("len%0d_writes", len), got_q.size(), nwords);
    check($sformatf("len%0d_reads", len), rd_cnt, len);
    check($sformatf("len%0d_stable", len), viol, 0);
    check($sformatf("len%0d_idle", len), busy, 1'b0);
    if (len == 0) check("len0_done_latency", first_done, 0);
    for (int j = 0; j < nwords && j < got_q.size(); j++)
      check($sformatf("len%0d_word%0d", len, j), got_q[j],
            {ADDR_W'(int'(dst) + j), exp_q[j]});
  endtask

  task automatic fill(input logic [ADDR_W-1:0] src, input int n, input bit ramp);
    for (int i = 0; i < n; i++) begin
      int v;
      v = ramp ? i + 1 : (($urandom_range(3) == 0) ? int'($urandom) : int'($urandom_range(2000)) - 1000);
      acc_mem[ADDR_W'(int'(src) + i)] = 32'(v);
    end
  endtask

  initial begin
    int aborted_done;
    for (int i = 0; i < 1024; i++) acc_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, acc_rd_en, q_valid, out_wr_en, out_wr_addr, out_wr_data}, '0);
    reset = 1'b0;

    fill(10'd0, 8, 1'b1);
    run_job(8, 10'd0, 10'd100, ONE, 100, -1, 0, 1'b0);

    acc_mem[200] = 32'd300; acc_mem[201] = -32'sd300;
    acc_mem[202] = 32'd127; acc_mem[203] = -32'sd128;
    run_job(4, 10'd200, 10'd50, ONE, 100, -1, 0, 1'b1);

    fill(10'd300, 5, 1'b1);
    run_job(5, 10'd300, 10'd1023, ONE, 100, -1, 0, 1'b0);

    fill(10'd400, 64, 1'b0);
    run_job(64, 10'd400, 10'd10, ONE, 100, 20, 20, 1'b1);

    run_job(0, 10'd0, 10'd0, ONE, 100, -1, 0, 1'b0);

    // Abort a running job, then confirm a fresh job ignores leftover quantizer results.
    fill(10'd600, 64, 1'b0);
    @(negedge clk);
    length = 16'd64; src_base = 10'd600; dst_base = 10'd0; scale = ONE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    aborted_done = 0;
    repeat (12) begin @(negedge clk); if (done) aborted_done++; end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) begin @(negedge clk); if (done) aborted_done++; end
    check("abort_no_done", aborted_done, 0);
    fill(10'd700, 4, 1'b0);
    run_job(4, 10'd700, 10'd20, ONE, 100, -1, 0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      int len, pct;
      logic [ADDR_W-1:0] src, dst;
      logic [31:0] scl;
      len = $urandom_range(1, 40);
      src = ADDR_W'($urandom);
      dst = (t % 3 == 0) ? 10'd1020 : ADDR_W'($urandom);
      scl = (t % 2 == 0) ? ONE : 32'h0040_0000 + $urandom_range(32'h03C0_0000);
      pct = (t % 3 == 0) ? 100 : ((t % 3 == 1) ? 70 : 35);
      fill(src, len, 1'b0);
      run_job(len, src, dst, scl, pct, -1, 0, (len >= 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
